// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..ROUNDS-1] using a
// 16-word sliding window and streams one word per valid/ready handshake.
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] block_in,
  input  logic         w_ready,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE,
    RUN
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] window [16];
  logic [5:0]  t;
  logic [31:0] newWord;
  logic        lastWord;
  logic        loadBlock;
  logic        advance;
  logic        finish;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign lastWord = (t == 6'(ROUNDS - 1));
  assign newWord  = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // abort outranks both start (in IDLE) and the handshake (in RUN)
  always_comb begin
    nextState = state;
    loadBlock = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          nextState = RUN;
          loadBlock = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          nextState = IDLE;
        end else if (w_ready) begin
          advance = 1'b1;
          if (lastWord) begin
            nextState = IDLE;
            finish    = 1'b1;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) window[i] <= '0;
      t    <= '0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (loadBlock) begin
        for (int unsigned i = 0; i < 16; i++) window[i] <= block_in[32*(15-i) +: 32];
        t <= '0;
      end else if (advance) begin
        for (int unsigned i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= newWord;
        // hold t at ROUNDS-1 on the final word so the index never runs past the block
        if (!lastWord) t <= t + 6'd1;
      end
    end
  end

  assign w_valid = (state == RUN);
  assign busy    = (state == RUN);
  assign w_out   = window[0];
  assign w_index = t;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized self-checking bench for sha256_msg_schedule against a direct W[t] recurrence model.
module tb_sha256_msg_schedule;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic         abort;
  logic [511:0] block_in;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         busy;
  logic         done;

  int nCmp = 0;
  int nErr = 0;

  logic [31:0] expW [64];
  logic [31:0] obsW [$];
  logic [5:0]  obsIdx [$];
  logic [31:0] stallW [$];
  logic [5:0]  stallIdx [$];
  int          doneCount;
  bit          ended;

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .block_in(block_in), .w_ready(w_ready), .w_valid(w_valid), .w_out(w_out),
    .w_index(w_index), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  // Model: W[t] from the block words, then the textbook recurrence over the full array.
  function automatic void buildModel(input logic [511:0] b);
    for (int k = 0; k < 16; k++) expW[k] = b[511 - 32*k -: 32];
    for (int k = 16; k < 64; k++)
      expW[k] = (ror(expW[k-2], 17) ^ ror(expW[k-2], 19) ^ (expW[k-2] >> 10))
              + expW[k-7]
              + (ror(expW[k-15], 7) ^ ror(expW[k-15], 18) ^ (expW[k-15] >> 3))
              + expW[k-16];
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic kick(input logic [511:0] b);
    block_in = b;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    block_in = randBlock();
  endtask

  // Stimulus/collection only. pokeKind: 0 none, 1 start with pokeBlock, 2 abort, 3 return at pokeAt.
  task automatic drain(input int stallAt, input int stallLen, input int pokeAt,
                       input int pokeKind, input logic [511:0] pokeBlock);
    int  stallCnt;
    bit  poked;
    stallCnt = 0;
    poked    = 1'b0;
    ended    = 1'b0;
    doneCount = 0;
    obsW.delete(); obsIdx.delete(); stallW.delete(); stallIdx.delete();
    for (int c = 0; c < 400; c++) begin
      start = 1'b0; abort = 1'b0; w_ready = 1'b1;
      if (done) doneCount++;
      if (!w_valid) begin ended = 1'b1; break; end
      if (stallAt >= 0 && int'(w_index) == stallAt && stallCnt < stallLen) begin
        w_ready = 1'b0;
        stallCnt++;
        stallIdx.push_back(w_index);
        stallW.push_back(w_out);
      end else if (pokeKind != 0 && !poked && int'(w_index) == pokeAt) begin
        poked = 1'b1;
        if (pokeKind == 1) begin start = 1'b1; block_in = pokeBlock; end
        if (pokeKind == 2) abort = 1'b1;
        if (pokeKind == 3) begin w_ready = 1'b0; ended = 1'b1; break; end
      end
      if (w_ready && !abort) begin
        obsIdx.push_back(w_index);
        obsW.push_back(w_out);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; w_ready = 1'b0; block_in = '0;
    #3;
    nCmp++;
    if ({w_valid, busy, done} !== 3'b000 || w_out !== 32'h0 || w_index !== 6'd0) begin
      nErr++;
      $display("FAIL reset_state: got valid=%b busy=%b done=%b out=%h idx=%0d, want all zero",
               w_valid, busy, done, w_out, w_index);
    end
    @(negedge clock);
    reset_n = 1'b1;
    w_ready = 1'b1;
    repeat (3) @(negedge clock);
    nCmp++;
    if (w_valid !== 1'b0 || busy !== 1'b0) begin
      nErr++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", w_valid, busy);
    end
    start = 1'b1; abort = 1'b1; block_in = randBlock();
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    nCmp++;
    if (w_valid !== 1'b0) begin
      nErr++;
      $display("FAIL abort_beats_start_idle: got valid=%b, want 0", w_valid);
    end
  endtask

  task automatic test_abc();
    buildModel(ABC_BLOCK);
    kick(ABC_BLOCK);
    nCmp++;
    if (w_valid !== 1'b1 || w_out !== 32'h61626380 || w_index !== 6'd0) begin
      nErr++;
      $display("FAIL abc_first: got valid=%b out=%h idx=%0d, want 1 61626380 0", w_valid, w_out, w_index);
    end
    drain(-1, 0, 0, 0, '0);
    nCmp++;
    if (!ended || obsW.size() != 64) begin
      nErr++;
      $display("FAIL abc_count: got %0d words ended=%b, want 64 ended=1", obsW.size(), ended);
    end else begin
      for (int i = 0; i < 64; i++) begin
        nCmp++;
        if (obsW[i] !== expW[i] || obsIdx[i] !== 6'(i)) begin
          nErr++;
          $display("FAIL abc_word: got W[%0d]=%h, want W[%0d]=%h", obsIdx[i], obsW[i], i, expW[i]);
        end
      end
      nCmp++;
      if (obsW[15] !== 32'h18 || obsW[16] !== 32'h61626380 || obsW[17] !== 32'h000F0000 ||
          obsW[18] !== 32'h7DA86405) begin
        nErr++;
        $display("FAIL abc_known: got %h %h %h %h, want 00000018 61626380 000f0000 7da86405",
                 obsW[15], obsW[16], obsW[17], obsW[18]);
      end
    end
    nCmp++;
    if (doneCount != 1 || busy !== 1'b0) begin
      nErr++;
      $display("FAIL abc_done: got done_count=%0d busy=%b, want 1 0", doneCount, busy);
    end
    @(negedge clock);
    nCmp++;
    if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) begin
      nErr++;
      $display("FAIL abc_done_pulse: got done=%b busy=%b valid=%b, want 0 0 0", done, busy, w_valid);
    end
  endtask

  task automatic test_zero();
    buildModel('0);
    kick('0);
    drain(-1, 0, 0, 0, '0);
    nCmp++;
    if (!ended || obsW.size() != 64 || doneCount != 1) begin
      nErr++;
      $display("FAIL zero_count: got %0d words done=%0d, want 64 1", obsW.size(), doneCount);
    end else begin
      for (int i = 0; i < 64; i++) begin
        nCmp++;
        if (obsW[i] !== 32'h0 || obsIdx[i] !== 6'(i)) begin
          nErr++;
          $display("FAIL zero_word: got idx=%0d w=%h, want idx=%0d w=0", obsIdx[i], obsW[i], i);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    buildModel(ABC_BLOCK);
    kick(ABC_BLOCK);
    drain(20, 5, 0, 0, '0);
    nCmp++;
    if (stallW.size() != 5) begin
      nErr++;
      $display("FAIL stall_len: got %0d stalled cycles, want 5", stallW.size());
    end
    for (int i = 0; i < stallW.size(); i++) begin
      nCmp++;
      if (stallW[i] !== expW[20] || stallIdx[i] !== 6'd20) begin
        nErr++;
        $display("FAIL stall_hold: got idx=%0d w=%h, want idx=20 w=%h", stallIdx[i], stallW[i], expW[20]);
      end
    end
    nCmp++;
    if (obsW.size() != 64 || doneCount != 1) begin
      nErr++;
      $display("FAIL bp_count: got %0d words done=%0d, want 64 1", obsW.size(), doneCount);
    end else begin
      for (int i = 0; i < 64; i++) begin
        nCmp++;
        if (obsW[i] !== expW[i] || obsIdx[i] !== 6'(i)) begin
          nErr++;
          $display("FAIL bp_word: got W[%0d]=%h, want W[%0d]=%h", obsIdx[i], obsW[i], i, expW[i]);
        end
      end
    end
  endtask

  task automatic test_start_in_run();
    logic [511:0] blkA, blkB;
    blkA = randBlock();
    blkB = randBlock();
    buildModel(blkA);
    kick(blkA);
    drain(-1, 0, 10, 1, blkB);
    nCmp++;
    if (obsW.size() != 64 || doneCount != 1) begin
      nErr++;
      $display("FAIL start_run_count: got %0d words done=%0d, want 64 1", obsW.size(), doneCount);
    end else begin
      for (int i = 0; i < 64; i++) begin
        nCmp++;
        if (obsW[i] !== expW[i] || obsIdx[i] !== 6'(i)) begin
          nErr++;
          $display("FAIL start_run_word: got W[%0d]=%h, want W[%0d]=%h", obsIdx[i], obsW[i], i, expW[i]);
        end
      end
    end
    // still in the done cycle: a start here must be accepted
    buildModel(blkB);
    kick(blkB);
    nCmp++;
    if (w_valid !== 1'b1 || w_out !== expW[0] || w_index !== 6'd0) begin
      nErr++;
      $display("FAIL start_on_done: got valid=%b out=%h idx=%0d, want 1 %h 0", w_valid, w_out, w_index, expW[0]);
    end
    drain(-1, 0, 0, 0, '0);
    nCmp++;
    if (obsW.size() != 64 || obsW[63] !== expW[63] || obsW[40] !== expW[40] || doneCount != 1) begin
      nErr++;
      $display("FAIL start_on_done_seq: got n=%0d w40=%h w63=%h, want 64 %h %h",
               obsW.size(), obsW.size() > 63 ? obsW[40] : 32'h0, obsW.size() > 63 ? obsW[63] : 32'h0,
               expW[40], expW[63]);
    end
    @(negedge clock);
  endtask

  task automatic test_abort();
    logic [511:0] blk;
    blk = randBlock();
    buildModel(blk);
    kick(blk);
    drain(-1, 0, 30, 2, '0);
    nCmp++;
    if (!ended || obsW.size() != 30 || doneCount != 0 || busy !== 1'b0 || w_valid !== 1'b0) begin
      nErr++;
      $display("FAIL abort: got n=%0d done=%0d busy=%b valid=%b, want 30 0 0 0",
               obsW.size(), doneCount, busy, w_valid);
    end
    @(negedge clock);
    nCmp++;
    if (done !== 1'b0 || w_valid !== 1'b0) begin
      nErr++;
      $display("FAIL abort_quiet: got done=%b valid=%b, want 0 0", done, w_valid);
    end
    blk = randBlock();
    buildModel(blk);
    kick(blk);
    drain(-1, 0, 0, 0, '0);
    nCmp++;
    if (obsW.size() != 64 || doneCount != 1) begin
      nErr++;
      $display("FAIL abort_next_count: got %0d words done=%0d, want 64 1", obsW.size(), doneCount);
    end else begin
      for (int i = 0; i < 64; i++) begin
        nCmp++;
        if (obsW[i] !== expW[i]) begin
          nErr++;
          $display("FAIL abort_next_word: got W[%0d]=%h, want %h", i, obsW[i], expW[i]);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    logic [511:0] blk;
    blk = randBlock();
    buildModel(blk);
    kick(blk);
    drain(-1, 0, 40, 3, '0);
    nCmp++;
    if (w_index !== 6'd40 || w_out !== expW[40]) begin
      nErr++;
      $display("FAIL pre_reset: got idx=%0d w=%h, want 40 %h", w_index, w_out, expW[40]);
    end
    #2 reset_n = 1'b0;
    #1;
    nCmp++;
    if ({w_valid, busy, done} !== 3'b000 || w_out !== 32'h0 || w_index !== 6'd0) begin
      nErr++;
      $display("FAIL async_reset: got valid=%b busy=%b done=%b out=%h idx=%0d, want all zero",
               w_valid, busy, done, w_out, w_index);
    end
    @(negedge clock);
    reset_n = 1'b1;
    w_ready = 1'b1;
    repeat (4) @(negedge clock);
    nCmp++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nErr++;
      $display("FAIL post_reset_idle: got valid=%b busy=%b done=%b, want 0 0 0", w_valid, busy, done);
    end
    blk = randBlock();
    buildModel(blk);
    kick(blk);
    drain(7, 2, 0, 0, '0);
    nCmp++;
    if (obsW.size() != 64 || doneCount != 1) begin
      nErr++;
      $display("FAIL post_reset_count: got %0d words done=%0d, want 64 1", obsW.size(), doneCount);
    end else begin
      for (int i = 0; i < 64; i++) begin
        nCmp++;
        if (obsW[i] !== expW[i] || obsIdx[i] !== 6'(i)) begin
          nErr++;
          $display("FAIL post_reset_word: got W[%0d]=%h, want W[%0d]=%h", obsIdx[i], obsW[i], i, expW[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_start_in_run();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
